// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Elastic pipeline-stage register carrying a payload plus per-instruction
//   flag bits under a valid/ready handshake. With SKID=1 a second (skid)
//   entry absorbs the cycle of latency on in_ready, so in_ready comes
//   straight from a register and has no combinational dependence on
//   out_ready. With SKID=0 the stage is a single register whose in_ready
//   is combinational from out_ready.
//   Invalid entries always hold all-zero payload and flags, so an empty
//   slot reads as a NOP (IR=0).
//
// Parameters
//   DW    payload width in bits
//   FW    flag width in bits
//   SKID  1 = two-entry skid buffer, 0 = single register
//
// Ports
//   clk        clock, rising edge
//   clr        synchronous active-high clear of all state
//   flush      synchronous active-high flush, same effect as clr
//   in_valid   upstream offers an entry
//   in_ready   stage accepts this cycle
//   in_data    upstream payload
//   in_flags   upstream flags
//   out_valid  head entry valid
//   out_ready  downstream consumes head this cycle
//   out_data   head payload (zero when out_valid=0)
//   out_flags  head flags (zero when out_valid=0)
//   occ        number of entries held (0..2)
module pipe_stage_skid #(
   parameter int unsigned DW   = 128,
   parameter int unsigned FW   = 4,
   parameter int unsigned SKID = 1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [FW-1:0] in_flags,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [FW-1:0] out_flags,
   output logic [1:0]    occ
);

   // Head (main) entry and the overflow (skid) entry behind it.
   logic          main_v;
   logic [DW-1:0] main_data;
   logic [FW-1:0] main_flags;
   logic          skid_v;
   logic [DW-1:0] skid_data;
   logic [FW-1:0] skid_flags;

   logic accept;
   logic pop;

   // With a skid entry, in_ready only drops once the skid slot is taken,
   // which is a pure register output. Without it, a full main register can
   // still accept when the head is being popped in the same cycle.
   assign in_ready  = (SKID != 0) ? ~skid_v : (~main_v | out_ready);

   assign accept    = in_valid & in_ready;
   assign pop       = main_v & out_ready;

   assign out_valid = main_v;
   assign out_data  = main_data;
   assign out_flags = main_flags;
   assign occ       = {1'b0, main_v} + {1'b0, skid_v};

   // Stage boundary: upstream handshake -> head/skid registers
   always_ff @(posedge clk) begin
      if (clr || flush) begin
         // Flush outranks any simultaneous accept: the offered entry is dropped.
         main_v     <= 1'b0;
         main_data  <= '0;
         main_flags <= '0;
         skid_v     <= 1'b0;
         skid_data  <= '0;
         skid_flags <= '0;
      end else if (SKID != 0) begin
         if (skid_v) begin
            // FULL: no accept possible; a pop promotes the skid entry.
            if (pop) begin
               main_data  <= skid_data;
               main_flags <= skid_flags;
               skid_v     <= 1'b0;
               skid_data  <= '0;
               skid_flags <= '0;
            end
         end else if (main_v) begin
            // ONE
            if (pop && accept) begin
               main_data  <= in_data;
               main_flags <= in_flags;
            end else if (pop) begin
               main_v     <= 1'b0;
               main_data  <= '0;
               main_flags <= '0;
            end else if (accept) begin
               skid_v     <= 1'b1;
               skid_data  <= in_data;
               skid_flags <= in_flags;
            end
         end else if (accept) begin
            // EMPTY
            main_v     <= 1'b1;
            main_data  <= in_data;
            main_flags <= in_flags;
         end
      end else begin
         if (accept) begin
            main_v     <= 1'b1;
            main_data  <= in_data;
            main_flags <= in_flags;
         end else if (pop) begin
            main_v     <= 1'b0;
            main_data  <= '0;
            main_flags <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

   localparam int DW = 128;
   localparam int FW = 4;

   logic clk = 1'b0;
   logic clr;
   logic flush;

   // SKID=1 instance
   logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [DW-1:0] a_in_data, a_out_data;
   logic [FW-1:0] a_in_flags, a_out_flags;
   logic [1:0]    a_occ;

   // SKID=0 instance
   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [DW-1:0] b_in_data, b_out_data;
   logic [FW-1:0] b_in_flags, b_out_flags;
   logic [1:0]    b_occ;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DW(DW), .FW(FW), .SKID(1)) u_skid (
      .clk(clk), .clr(clr), .flush(flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_flags(a_in_flags),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_flags(a_out_flags),
      .occ(a_occ)
   );

   pipe_stage_skid #(.DW(DW), .FW(FW), .SKID(0)) u_single (
      .clk(clk), .clr(clr), .flush(flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_flags(b_in_flags),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_flags(b_out_flags),
      .occ(b_occ)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_state(input string tag, input logic v, input logic [DW-1:0] d,
                          input logic [FW-1:0] f, input logic [1:0] o, input logic r);
      check({tag, ".out_valid"}, DW'(a_out_valid), DW'(v));
      check({tag, ".out_data"},  a_out_data,       d);
      check({tag, ".out_flags"}, DW'(a_out_flags), DW'(f));
      check({tag, ".occ"},       DW'(a_occ),       DW'(o));
      check({tag, ".in_ready"},  DW'(a_in_ready),  DW'(r));
   endtask

   task automatic b_state(input string tag, input logic v, input logic [DW-1:0] d,
                          input logic [1:0] o);
      check({tag, ".b_out_valid"}, DW'(b_out_valid), DW'(v));
      check({tag, ".b_out_data"},  b_out_data,       d);
      check({tag, ".b_occ"},       DW'(b_occ),       DW'(o));
   endtask

   initial begin
      clr = 1'b1; flush = 1'b0;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0; a_in_flags = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0; b_in_flags = '0;
      step();
      clr = 1'b0;

      // Reset state
      a_state("rst", 1'b0, 0, 4'h0, 2'd0, 1'b1);
      b_state("rst", 1'b0, 0, 2'd0);
      check("rst.b_in_ready", DW'(b_in_ready), 1);
      step();
      a_state("idle", 1'b0, 0, 4'h0, 2'd0, 1'b1);

      // Streaming with out_ready=1: 1-cycle latency, occ stays 1
      a_out_ready = 1'b1; a_in_valid = 1'b1;
      a_in_data = 1; a_in_flags = 4'h1; step();
      a_state("stream1", 1'b1, 1, 4'h1, 2'd1, 1'b1);
      a_in_data = 2; a_in_flags = 4'h2; step();
      a_state("stream2", 1'b1, 2, 4'h2, 2'd1, 1'b1);
      a_in_data = 3; a_in_flags = 4'h3; step();
      a_state("stream3", 1'b1, 3, 4'h3, 2'd1, 1'b1);
      a_in_valid = 1'b0; a_in_data = 0; a_in_flags = 0; step();
      a_state("drain", 1'b0, 0, 4'h0, 2'd0, 1'b1);

      // Stall fills the skid entry; third offer must wait
      a_out_ready = 1'b0; a_in_valid = 1'b1;
      a_in_data = 'h11; a_in_flags = 4'h1; step();
      a_state("pushA", 1'b1, 'h11, 4'h1, 2'd1, 1'b1);
      a_in_data = 'h22; a_in_flags = 4'h2; step();
      a_state("pushB", 1'b1, 'h11, 4'h1, 2'd2, 1'b0);
      a_in_data = 'h33; a_in_flags = 4'h3; step();
      a_state("offerC", 1'b1, 'h11, 4'h1, 2'd2, 1'b0);
      a_out_ready = 1'b1; #1;
      check("popA.out_data", a_out_data, 'h11);
      check("popA.in_ready_reg", DW'(a_in_ready), 0);
      step();
      a_state("popB", 1'b1, 'h22, 4'h2, 2'd1, 1'b1);
      step();
      a_state("popC", 1'b1, 'h33, 4'h3, 2'd1, 1'b1);
      a_in_valid = 1'b0; a_in_data = 0; a_in_flags = 0; step();
      a_state("empty", 1'b0, 0, 4'h0, 2'd0, 1'b1);

      // Flush at occ=2 drops a simultaneously offered entry
      a_out_ready = 1'b0; a_in_valid = 1'b1;
      a_in_data = 'h11; a_in_flags = 4'h1; step();
      a_in_data = 'h22; a_in_flags = 4'h2; step();
      a_state("prefl", 1'b1, 'h11, 4'h1, 2'd2, 1'b0);
      flush = 1'b1; a_in_data = 'h44; a_in_flags = 4'hf; step();
      a_state("flush", 1'b0, 0, 4'h0, 2'd0, 1'b1);
      flush = 1'b0; a_in_valid = 1'b0; a_in_data = 0; a_in_flags = 0;
      a_out_ready = 1'b1; step();
      a_state("postfl", 1'b0, 0, 4'h0, 2'd0, 1'b1);

      // Flags travel with payload; clr mid-stall clears everything
      a_out_ready = 1'b0; a_in_valid = 1'b1;
      a_in_data = 'h66; a_in_flags = 4'b1010; step();
      a_in_data = 'h77; a_in_flags = 4'b0101; step();
      a_state("fstall", 1'b1, 'h66, 4'b1010, 2'd2, 1'b0);
      step();
      a_state("fhold", 1'b1, 'h66, 4'b1010, 2'd2, 1'b0);
      clr = 1'b1; step();
      clr = 1'b0;
      a_state("fclr", 1'b0, 0, 4'h0, 2'd0, 1'b1);
      a_out_ready = 1'b1; a_in_data = 'h66; a_in_flags = 4'b1010; step();
      a_state("fresend", 1'b1, 'h66, 4'b1010, 2'd1, 1'b1);
      a_in_valid = 1'b0; a_in_data = 0; a_in_flags = 0; step();
      a_state("fdone", 1'b0, 0, 4'h0, 2'd0, 1'b1);

      // SKID=0: combinational in_ready from out_ready
      b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 'h50; step();
      b_state("b_load", 1'b1, 'h50, 2'd1);
      b_in_valid = 1'b0; #1;
      check("b_full.in_ready", DW'(b_in_ready), 0);
      b_in_valid = 1'b1; b_in_data = 'h55; #1;
      check("b_full_offer.in_ready", DW'(b_in_ready), 0);
      b_out_ready = 1'b1; #1;
      check("b_comb.in_ready", DW'(b_in_ready), 1);
      step();
      b_state("b_pass", 1'b1, 'h55, 2'd1);
      b_in_valid = 1'b0; b_in_data = 0; step();
      b_state("b_pop", 1'b0, 0, 2'd0);
      b_in_valid = 1'b1; b_in_data = 'h99; b_out_ready = 1'b0; step();
      b_state("b_fill", 1'b1, 'h99, 2'd1);
      flush = 1'b1; b_in_data = 'haa; step();
      flush = 1'b0; b_in_valid = 1'b0; b_in_data = 0;
      b_state("b_flush", 1'b0, 0, 2'd0);
      check("b_flush.in_ready", DW'(b_in_ready), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
